// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//   Y86-64 pipeline execute stage. Selects the ALU operands from the E pipeline
//   register fields, computes the ALU result and the new condition flags,
//   evaluates the jXX/cmovXX condition against the architectural condition-code
//   register, and owns the M pipeline register that feeds the memory stage.
//
// Optional feature (compile-time macro EXEC_PERF_CNT_EN):
//   adds two saturating 32-bit counters, perf_opq and perf_jtaken, counting
//   OPq instructions and taken jXX instructions that enter the M register.
//
// Ports
//   clk, rst_n         rising-edge clock, synchronous active-low reset
//   E_stat/E_icode/E_ifun/E_valC/E_valA/E_valB/E_dstE/E_dstM
//                      E pipeline register fields
//   m_stat, W_stat     status of the instructions in memory and writeback;
//                      any exception there suppresses the CC update
//   M_stall, M_bubble  M register hold / NOP insertion (stall has priority)
//   e_valE, e_dstE, e_Cnd
//                      combinational ALU result, effective dstE and condition
//                      (forwarding paths)
//   M_icode..M_dstM    M pipeline register
//   perf_opq, perf_jtaken
//                      performance counters (EXEC_PERF_CNT_EN only)
//   cc_out             condition codes {ZF,SF,OF}
// -----------------------------------------------------------------------------
module execute_stage #(
  parameter logic [3:0] RNONE    = 4'hF,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  E_stat,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_ifun,
  input  logic [63:0] E_valC,
  input  logic [63:0] E_valA,
  input  logic [63:0] E_valB,
  input  logic [3:0]  E_dstE,
  input  logic [3:0]  E_dstM,
  input  logic [1:0]  m_stat,
  input  logic [1:0]  W_stat,
  input  logic        M_stall,
  input  logic        M_bubble,
  output logic [63:0] e_valE,
  output logic [3:0]  e_dstE,
  output logic        e_Cnd,
  output logic [3:0]  M_icode,
  output logic [1:0]  M_stat,
  output logic        M_Cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
`ifdef EXEC_PERF_CNT_EN
  output logic [31:0] perf_opq,
  output logic [31:0] perf_jtaken,
`endif
  output logic [2:0]  cc_out
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] S_AOK    = 2'b00;

  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [63:0] alu_result;
  logic        of_next;
  logic [2:0]  cc_next;
  logic        set_cc;
  logic        cond;
  logic        load_m;

  logic [2:0]  cc_reg;
  logic [3:0]  m_icode_reg;
  logic [1:0]  m_stat_reg;
  logic        m_cnd_reg;
  logic [63:0] m_val_e_reg;
  logic [63:0] m_val_a_reg;
  logic [3:0]  m_dst_e_reg;
  logic [3:0]  m_dst_m_reg;

  // ---------------------------------------------------------------------------
  // Operand selection
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_a = '0;
    unique case (E_icode)
      I_CMOVXX, I_OPQ:            alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
      I_CALL, I_PUSHQ:            alu_a = -64'sd8;
      I_RET, I_POPQ:              alu_a = 64'd8;
      default:                    alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    unique case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = E_valB;
      default:                                                   alu_b = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU. Only OPq honours ifun; everything else is an address/stack add.
  // An undefined OPq function yields 0 with OF clear.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_result = alu_b + alu_a;
    of_next    = 1'b0;
    if (E_icode == I_OPQ) begin
      unique case (E_ifun)
        4'h0: begin
          alu_result = alu_b + alu_a;
          of_next    = (alu_a[63] == alu_b[63]) && (alu_result[63] != alu_a[63]);
        end
        4'h1: begin
          alu_result = alu_b - alu_a;
          of_next    = (alu_a[63] != alu_b[63]) && (alu_result[63] != alu_b[63]);
        end
        4'h2:    alu_result = alu_b & alu_a;
        4'h3:    alu_result = alu_b ^ alu_a;
        default: alu_result = '0;
      endcase
    end
  end

  assign cc_next = {(alu_result == 64'd0), alu_result[63], of_next};

  // A younger instruction must not change CC once an older one has faulted.
  assign set_cc = (E_icode == I_OPQ) && (m_stat == S_AOK) && (W_stat == S_AOK);

  // ---------------------------------------------------------------------------
  // Condition evaluation uses the committed CC, not this cycle's new flags.
  // ---------------------------------------------------------------------------
  always_comb begin
    cond = 1'b0;
    unique case (E_ifun)
      4'h0:    cond = 1'b1;
      4'h1:    cond = (cc_reg[1] ^ cc_reg[0]) | cc_reg[2];
      4'h2:    cond = cc_reg[1] ^ cc_reg[0];
      4'h3:    cond = cc_reg[2];
      4'h4:    cond = ~cc_reg[2];
      4'h5:    cond = ~(cc_reg[1] ^ cc_reg[0]);
      4'h6:    cond = ~(cc_reg[1] ^ cc_reg[0]) & ~cc_reg[2];
      default: cond = 1'b0;
    endcase
  end

  assign e_Cnd  = ((E_icode == I_CMOVXX) || (E_icode == I_JXX)) ? cond : 1'b0;
  assign e_valE = alu_result;
  // A cmov that is not taken must not write its destination.
  assign e_dstE = ((E_icode == I_CMOVXX) && !e_Cnd) ? RNONE : E_dstE;

  assign load_m = !M_stall && !M_bubble;

  // ---------------------------------------------------------------------------
  // Condition-code register (independent of M_stall)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc_reg <= CC_RESET;
    end else if (set_cc) begin
      cc_reg <= cc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // M pipeline register: stall holds, bubble inserts a NOP, else load from E.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_icode_reg <= I_NOP;
      m_stat_reg  <= S_AOK;
      m_cnd_reg   <= 1'b0;
      m_val_e_reg <= '0;
      m_val_a_reg <= '0;
      m_dst_e_reg <= RNONE;
      m_dst_m_reg <= RNONE;
    end else if (!M_stall) begin
      if (M_bubble) begin
        m_icode_reg <= I_NOP;
        m_stat_reg  <= S_AOK;
        m_cnd_reg   <= 1'b0;
        m_val_e_reg <= '0;
        m_val_a_reg <= '0;
        m_dst_e_reg <= RNONE;
        m_dst_m_reg <= RNONE;
      end else begin
        m_icode_reg <= E_icode;
        m_stat_reg  <= E_stat;
        m_cnd_reg   <= e_Cnd;
        m_val_e_reg <= e_valE;
        m_val_a_reg <= E_valA;
        m_dst_e_reg <= e_dstE;
        m_dst_m_reg <= E_dstM;
      end
    end
  end

  assign M_icode = m_icode_reg;
  assign M_stat  = m_stat_reg;
  assign M_Cnd   = m_cnd_reg;
  assign M_valE  = m_val_e_reg;
  assign M_valA  = m_val_a_reg;
  assign M_dstE  = m_dst_e_reg;
  assign M_dstM  = m_dst_m_reg;
  assign cc_out  = cc_reg;

`ifdef EXEC_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating event counters, advanced only when E actually moves into M.
  // ---------------------------------------------------------------------------
  logic [31:0] perf_opq_reg;
  logic [31:0] perf_jtaken_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_opq_reg    <= '0;
      perf_jtaken_reg <= '0;
    end else if (load_m) begin
      if ((E_icode == I_OPQ) && (perf_opq_reg != 32'hFFFF_FFFF)) begin
        perf_opq_reg <= perf_opq_reg + 32'd1;
      end
      if ((E_icode == I_JXX) && e_Cnd && (perf_jtaken_reg != 32'hFFFF_FFFF)) begin
        perf_jtaken_reg <= perf_jtaken_reg + 32'd1;
      end
    end
  end

  assign perf_opq    = perf_opq_reg;
  assign perf_jtaken = perf_jtaken_reg;
`else
  // load_m only feeds the performance counters.
  logic unused_load_m;
  assign unused_load_m = load_m;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
//   Self-checking bench for execute_stage. A behavioural model (plain wide
//   arithmetic and condition tables) predicts e_* every cycle and the M
//   register / CC after every clock edge. Directed scenarios with hand-computed
//   literals come first, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_execute_stage;

  logic        clk;
  logic        rst_n;
  logic [1:0]  E_stat;
  logic [3:0]  E_icode;
  logic [3:0]  E_ifun;
  logic [63:0] E_valC;
  logic [63:0] E_valA;
  logic [63:0] E_valB;
  logic [3:0]  E_dstE;
  logic [3:0]  E_dstM;
  logic [1:0]  m_stat;
  logic [1:0]  W_stat;
  logic        M_stall;
  logic        M_bubble;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_Cnd;
  logic [3:0]  M_icode;
  logic [1:0]  M_stat;
  logic        M_Cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic [2:0]  cc_out;
`ifdef EXEC_PERF_CNT_EN
  logic [31:0] perf_opq;
  logic [31:0] perf_jtaken;
`endif

  execute_stage dut (
    .clk(clk), .rst_n(rst_n),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
    .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat), .M_stall(M_stall), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .M_stat(M_stat), .M_Cnd(M_Cnd), .M_valE(M_valE),
    .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
`ifdef EXEC_PERF_CNT_EN
    .perf_opq(perf_opq), .perf_jtaken(perf_jtaken),
`endif
    .cc_out(cc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  bit          model_valid = 0;
  logic [2:0]  mod_cc;
  logic [3:0]  mod_icode;
  logic [1:0]  mod_stat;
  logic        mod_cnd;
  logic [63:0] mod_valE;
  logic [63:0] mod_valA;
  logic [3:0]  mod_dstE;
  logic [3:0]  mod_dstM;
  longint      mod_perf_opq;
  longint      mod_perf_jt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected combinational results from the instruction semantics.
  task automatic model_comb(output logic [63:0] ve, output logic c,
                            output logic [3:0] de, output logic [2:0] flags);
    logic [63:0] a, b;
    logic [64:0] wide;
    logic        ovf, zf, sf, of, lt;
    a = 64'd0; b = 64'd0; ovf = 1'b0;
    case (E_icode)
      4'h2, 4'h6:       a = E_valA;
      4'h3, 4'h4, 4'h5: a = E_valC;
      4'h8, 4'hA:       a = 64'hFFFF_FFFF_FFFF_FFF8;
      4'h9, 4'hB:       a = 64'd8;
      default:          a = 64'd0;
    endcase
    if (E_icode inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) b = E_valB;
    // Sign-extended 65-bit arithmetic: overflow iff the top two bits disagree.
    wide = {b[63], b} + {a[63], a};
    if (E_icode == 4'h6) begin
      case (E_ifun)
        4'h0: begin wide = {b[63], b} + {a[63], a}; ovf = wide[64] ^ wide[63]; end
        4'h1: begin wide = {b[63], b} - {a[63], a}; ovf = wide[64] ^ wide[63]; end
        4'h2: wide = {1'b0, b & a};
        4'h3: wide = {1'b0, b ^ a};
        default: wide = 65'd0;
      endcase
    end
    ve    = wide[63:0];
    flags = {ve == 64'd0, ve[63], ovf};
    zf = mod_cc[2]; sf = mod_cc[1]; of = mod_cc[0]; lt = sf ^ of;
    case (E_ifun)
      4'h0:    c = 1'b1;
      4'h1:    c = lt || zf;
      4'h2:    c = lt;
      4'h3:    c = zf;
      4'h4:    c = !zf;
      4'h5:    c = !lt;
      4'h6:    c = !lt && !zf;
      default: c = 1'b0;
    endcase
    if (!(E_icode == 4'h2 || E_icode == 4'h7)) c = 1'b0;
    de = (E_icode == 4'h2 && !c) ? 4'hF : E_dstE;
  endtask

  task automatic model_nop();
    mod_icode = 4'h1; mod_stat = 2'b00; mod_cnd = 1'b0;
    mod_valE = 64'd0; mod_valA = 64'd0; mod_dstE = 4'hF; mod_dstM = 4'hF;
  endtask

  // One cycle: compare everything against the model, clock, advance the model.
  task automatic step();
    logic [63:0] ve;
    logic        c;
    logic [3:0]  de;
    logic [2:0]  fl;
    #1;
    model_comb(ve, c, de, fl);
    if (model_valid) begin
      chk("e_valE", e_valE, ve);
      chk("e_Cnd", 64'(e_Cnd), 64'(c));
      chk("e_dstE", 64'(e_dstE), 64'(de));
      chk("M_icode", 64'(M_icode), 64'(mod_icode));
      chk("M_stat", 64'(M_stat), 64'(mod_stat));
      chk("M_Cnd", 64'(M_Cnd), 64'(mod_cnd));
      chk("M_valE", M_valE, mod_valE);
      chk("M_valA", M_valA, mod_valA);
      chk("M_dstE", 64'(M_dstE), 64'(mod_dstE));
      chk("M_dstM", 64'(M_dstM), 64'(mod_dstM));
      chk("cc_out", 64'(cc_out), 64'(mod_cc));
`ifdef EXEC_PERF_CNT_EN
      chk("perf_opq", 64'(perf_opq), 64'(mod_perf_opq));
      chk("perf_jtaken", 64'(perf_jtaken), 64'(mod_perf_jt));
`endif
    end
    @(posedge clk);
    if (!rst_n) begin
      mod_cc = 3'b100;
      model_nop();
      mod_perf_opq = 0; mod_perf_jt = 0;
      model_valid = 1;
    end else begin
      if (E_icode == 4'h6 && m_stat == 2'b00 && W_stat == 2'b00) mod_cc = fl;
      if (!M_stall) begin
        if (M_bubble) model_nop();
        else begin
          mod_icode = E_icode; mod_stat = E_stat; mod_cnd = c;
          mod_valE = ve; mod_valA = E_valA; mod_dstE = de; mod_dstM = E_dstM;
          if (E_icode == 4'h6 && mod_perf_opq < 64'hFFFF_FFFF) mod_perf_opq++;
          if (E_icode == 4'h7 && c && mod_perf_jt < 64'hFFFF_FFFF) mod_perf_jt++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic set_e(input logic [1:0] st, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb,
                       input logic [3:0] de, input logic [3:0] dm);
    E_stat = st; E_icode = ic; E_ifun = fn; E_valC = vc;
    E_valA = va; E_valB = vb; E_dstE = de; E_dstM = dm;
  endtask

  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h7FFF_FFFF_FFFF_FFFF;
      5: return 64'(9);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; m_stat = 2'b00; W_stat = 2'b00; M_stall = 1'b0; M_bubble = 1'b0;
    set_e(2'b00, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    @(negedge clk);

    // Reset
    step();
    chk("rst M_icode", 64'(M_icode), 64'h1);
    chk("rst M_dstE", 64'(M_dstE), 64'hF);
    chk("rst M_dstM", 64'(M_dstM), 64'hF);
    chk("rst M_valE", M_valE, 64'd0);
    chk("rst cc", 64'(cc_out), 64'b100);
    rst_n = 1'b1;

    // OPq add 7+5
    set_e(2'b00, 4'h6, 4'h0, 64'd0, 64'd5, 64'd7, 4'h2, 4'hF);
    step();
    chk("add M_valE", M_valE, 64'd12);
    chk("add M_icode", 64'(M_icode), 64'h6);
    chk("add cc", 64'(cc_out), 64'b000);

    // OPq sub overflow, then jl
    set_e(2'b00, 4'h6, 4'h1, 64'd0, 64'd1, 64'h8000_0000_0000_0000, 4'h2, 4'hF);
    #1 chk("sub e_valE", e_valE, 64'h7FFF_FFFF_FFFF_FFFF);
    step();
    chk("sub cc", 64'(cc_out), 64'b001);
    set_e(2'b00, 4'h7, 4'h2, 64'h100, 64'd0, 64'd0, 4'hF, 4'hF);
    #1 chk("jl e_Cnd", 64'(e_Cnd), 64'd1);
    step();

    // cmove with ZF=0, then ZF=1
    set_e(2'b00, 4'h2, 4'h3, 64'd0, 64'd33, 64'd0, 4'h3, 4'hF);
    #1 chk("cmove nz e_dstE", 64'(e_dstE), 64'hF);
    step();
    chk("cmove nz M_Cnd", 64'(M_Cnd), 64'd0);
    set_e(2'b00, 4'h6, 4'h3, 64'd0, 64'd9, 64'd9, 4'h4, 4'hF);
    step();
    chk("xor zf cc", 64'(cc_out), 64'b100);
    set_e(2'b00, 4'h2, 4'h3, 64'd0, 64'd33, 64'd0, 4'h3, 4'hF);
    #1 chk("cmove z e_dstE", 64'(e_dstE), 64'h3);
    step();

    // CC update suppressed by exception in memory stage
    set_e(2'b00, 4'h6, 4'h1, 64'd0, 64'd1, 64'h8000_0000_0000_0000, 4'h2, 4'hF);
    step();
    set_e(2'b01, 4'h6, 4'h3, 64'd0, 64'd9, 64'd9, 4'h4, 4'hF);
    m_stat = 2'b10;
    step();
    m_stat = 2'b00;
    chk("exc cc held", 64'(cc_out), 64'b001);
    chk("exc M_valE", M_valE, 64'd0);
    chk("exc M_stat", 64'(M_stat), 64'h1);

    // Stall / bubble / both
    set_e(2'b00, 4'h6, 4'h0, 64'd0, 64'd5, 64'd7, 4'h2, 4'hF);
    step();
    M_stall = 1'b1;
    set_e(2'b00, 4'h3, 4'h0, 64'd77, 64'd0, 64'd0, 4'h5, 4'hF);
    step();
    set_e(2'b00, 4'h5, 4'h0, 64'd16, 64'd0, 64'd4, 4'hF, 4'h6);
    step();
    chk("stall M_valE", M_valE, 64'd12);
    chk("stall M_icode", 64'(M_icode), 64'h6);
    M_stall = 1'b0; M_bubble = 1'b1;
    step();
    chk("bubble M_icode", 64'(M_icode), 64'h1);
    chk("bubble M_dstE", 64'(M_dstE), 64'hF);
    chk("bubble M_dstM", 64'(M_dstM), 64'hF);
    M_bubble = 1'b0;
    set_e(2'b00, 4'h6, 4'h0, 64'd0, 64'd1, 64'd2, 4'h2, 4'hF);
    step();
    M_stall = 1'b1; M_bubble = 1'b1;
    set_e(2'b00, 4'h3, 4'h0, 64'd99, 64'd0, 64'd0, 4'h5, 4'hF);
    step();
    chk("stall+bubble M_valE", M_valE, 64'd3);
    chk("stall+bubble M_icode", 64'(M_icode), 64'h6);
    M_stall = 1'b0; M_bubble = 1'b0;

    // pushq, then reset mid-stream
    set_e(2'b00, 4'hA, 4'h0, 64'd0, 64'd123, 64'd64, 4'h4, 4'hF);
    step();
    chk("pushq M_valE", M_valE, 64'd56);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst2 M_icode", 64'(M_icode), 64'h1);
    chk("rst2 M_valA", M_valA, 64'd0);
    chk("rst2 cc", 64'(cc_out), 64'b100);

    // Three OPq and one taken jmp
    for (int i = 0; i < 3; i++) begin
      set_e(2'b00, 4'h6, 4'(i), 64'd0, 64'(i + 1), 64'd40, 4'h1, 4'hF);
      step();
    end
    set_e(2'b00, 4'h7, 4'h0, 64'h200, 64'd0, 64'd0, 4'hF, 4'hF);
    step();
`ifdef EXEC_PERF_CNT_EN
    chk("perf_opq lit", 64'(perf_opq), 64'd3);
    chk("perf_jtaken lit", 64'(perf_jtaken), 64'd1);
`endif

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rst_n    = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      M_stall  = ($urandom_range(0, 9) == 0);
      M_bubble = ($urandom_range(0, 9) == 0);
      m_stat   = ($urandom_range(0, 9) < 8) ? 2'b00 : 2'($urandom_range(1, 3));
      W_stat   = ($urandom_range(0, 9) < 8) ? 2'b00 : 2'($urandom_range(1, 3));
      set_e(2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0) ? 4'h6 : 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6)),
            pick64(), pick64(), pick64(),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      step();
    end
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Y86-64 pipeline execute stage, directly upstream of the memory stage.
- Consumes the E pipeline register fields and computes ALU result, condition flags and branch/cmov condition.
- Holds the architectural condition-code register (CC).
- Owns the M pipeline register (M_icode, M_stat, M_Cnd, M_valE, M_valA, M_dstE, M_dstM) that feeds the memory stage.

Parameters:
- RNONE, 4'hF, register ID meaning "no destination".
- CC_RESET, 3'b100, reset value of {ZF,SF,OF}.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- E_stat  in  2  status: 00 AOK, 01 HLT, 10 ADR, 11 INS
- E_icode  in  4  instruction code
- E_ifun  in  4  function code
- E_valC  in  64  signed constant
- E_valA  in  64  signed operand A
- E_valB  in  64  signed operand B
- E_dstE  in  4  ALU destination register
- E_dstM  in  4  memory destination register
- m_stat  in  2  status currently in the memory stage
- W_stat  in  2  status currently in the writeback stage
- M_stall  in  1  hold the M register
- M_bubble  in  1  load NOP into the M register
- e_valE  out  64  combinational ALU result (forwarding)
- e_dstE  out  4  combinational effective dstE (forwarding)
- e_Cnd  out  1  combinational condition result
- M_icode, M_stat, M_Cnd, M_valE, M_valA, M_dstE, M_dstM  out  4/2/1/64/64/4/4  M pipeline register
- cc_out  out  3  {ZF,SF,OF}

Behaviour:
- Reset: rst_n sampled low at posedge takes priority over stall and bubble.
  - M_icode=4'h1 (nop), M_stat=00, M_Cnd=0, M_valE=0, M_valA=0, M_dstE=M_dstM=RNONE.
  - CC=CC_RESET.
- aluA selection:
  - valA for cmovXX(2) and OPq(6).
  - valC for irmovq(3), rmmovq(4), mrmovq(5).
  - -8 for call(8) and pushq(A).
  - +8 for ret(9) and popq(B).
  - 0 otherwise.
- aluB selection:
  - valB for icodes 4, 5, 6, 8, 9, A, B.
  - 0 otherwise.
- ALU function:
  - OPq uses ifun: 0 add (B+A), 1 sub (B-A), 2 and, 3 xor.
  - All other icodes add. OPq with ifun>3 yields 0.
  - Arithmetic is 64-bit modulo 2^64; wrap-around is not an error.
- Flags:
  - ZF = result==0; SF = result[63].
  - Add OF: A and B have equal signs and the result sign differs.
  - Sub OF: A and B have differing signs and result sign != B sign.
  - Logic ops: OF=0.
- set_cc = (E_icode==6) && m_stat==00 && W_stat==00.
  - CC updates at posedge when set_cc is true and rst_n is high.
  - CC updates regardless of M_stall, since the E-stage instruction is the one computing.
- Cnd from the current CC register (not the same-cycle new flags), ifun:
  - 0 always; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne !ZF; 5 ge !(SF^OF); 6 g !(SF^OF)&!ZF; ≥7 gives 0.
  - Cnd is meaningful for icodes 2 and 7; it is 0 for all other icodes.
- e_dstE = RNONE when E_icode==2 and !e_Cnd; otherwise E_dstE.
- M register update at posedge (rst_n high):
  - M_stall=1: hold all fields.
  - Else M_bubble=1: load the reset values.
  - Else load E_stat, E_icode, e_Cnd, e_valE, E_valA, e_dstE, E_dstM.
  - Stall and bubble asserted together: stall wins.
- Latency: e_* outputs are combinational (same cycle); M_* outputs appear 1 cycle later.

Optional Feature:
- Macro EXEC_PERF_CNT_EN.
- When defined, adds outputs perf_opq [31:0] and perf_jtaken [31:0], both reset to 0 by rst_n.
  - On each posedge that loads E data into M (not stall, not bubble): perf_opq increments if E_icode==6, and perf_jtaken increments if E_icode==7 and e_Cnd==1.
  - Both counters saturate at 32'hFFFFFFFF.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then OPq add with A=5, B=7 -> next cycle M_valE=12, M_icode=6, CC=000.
- OPq sub with A=1, B=64'h8000000000000000 -> e_valE=64'h7FFFFFFFFFFFFFFF, CC next cycle {0,0,1}. Then jXX ifun=2 (l) -> e_Cnd=1.
- cmovXX ifun=3 with ZF=0, E_dstE=3 -> e_dstE=4'hF, M_Cnd=0; with ZF=1 -> e_dstE=3.
- OPq xor A=B=9 with m_stat=10 -> CC unchanged, M_valE=0, M_stat=E_stat.
- M_stall=1 for 2 cycles with changing E inputs -> M_* constant; M_bubble=1 -> M_icode=1, M_dstE=M_dstM=F. Stall+bubble together -> hold.
- rst_n low mid-stream with pushq valB=64 -> M_* return to the nop values and CC=100. With EXEC_PERF_CNT_EN: 3 OPq + 1 taken jmp -> perf_opq=3, perf_jtaken=1.
